// File: rtl/led_pattern_pkg.sv
// led_pattern_pkg: shared mode and channel-state types for the LED pattern generator
package led_pattern_pkg;
  localparam logic [1:0] MODE_OFF   = 2'd0;
  localparam logic [1:0] MODE_ON    = 2'd1;
  localparam logic [1:0] MODE_BLINK = 2'd2;
  localparam logic [1:0] MODE_BURST = 2'd3;
  typedef enum logic [1:0] {OFF = MODE_OFF, ON = MODE_ON, BLINK = MODE_BLINK, BURST = MODE_BURST} mode_t;
  typedef enum logic [1:0] {IDLE, PH_ON, PH_OFF, GAP} chan_state_t;
endpackage

// File: rtl/led_channel.sv
// led_channel: per-channel config registers, pattern FSM and phase/pulse counters
module led_channel
  import led_pattern_pkg::*;
#(
  parameter int RATE_W  = 8,
  parameter int BURST_W = 4,
  parameter int GAP_HP  = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick,
  input  logic               load,
  input  logic [1:0]         mode,
  input  logic [RATE_W-1:0]  rate,
  input  logic [BURST_W-1:0] burst,
  output logic               led
);
  localparam int PW = RATE_W + $clog2(GAP_HP + 1);
  mode_t              md;
  chan_state_t        st;
  chan_state_t        start;
  logic [RATE_W-1:0]  rt;
  logic [BURST_W-1:0] bs;
  logic [BURST_W-1:0] pc;
  logic [PW-1:0]      ph;
  logic [PW-1:0]      lim;
  logic               done;
  always_comb begin
    lim   = st == GAP ? PW'(GAP_HP) * PW'(rt) : PW'(rt);
    done  = tick && ph == lim - 1'b1;
    start = (mode == MODE_BLINK || (mode == MODE_BURST && burst != '0)) ? PH_ON : IDLE;
  end
  // pc is compared against bs before it could pass it, so it never wraps
  always_ff @(posedge clk) begin
    if (rst) begin
      md  <= OFF;
      rt  <= RATE_W'(1);
      bs  <= '0;
      st  <= IDLE;
      ph  <= '0;
      pc  <= '0;
      led <= 1'b0;
    end else begin
      led <= st == PH_ON || (st == IDLE && md == ON);
      if (load) begin
        md <= mode_t'(mode);
        rt <= rate == '0 ? RATE_W'(1) : rate;
        bs <= burst;
        st <= start;
        ph <= '0;
        pc <= '0;
      end else if (tick && st != IDLE) begin
        ph <= done ? '0 : ph + 1'b1;
        if (done) begin
          st <= st == PH_ON ? PH_OFF : st == PH_OFF ? ((md == BURST && pc == bs) ? GAP : PH_ON) : PH_ON;
          pc <= (st == PH_ON && md == BURST) ? pc + 1'b1 : st == GAP ? '0 : pc;
        end
      end
    end
  end
endmodule

// File: rtl/led_pattern_gen.sv
// led_pattern_gen: shared tick prescaler plus NUM_CH independently programmable LED channels
module led_pattern_gen
  import led_pattern_pkg::*;
#(
  parameter int CLK_HZ  = 50000000,
  parameter int TICK_HZ = 1000,
  parameter int NUM_CH  = 4,
  parameter int RATE_W  = 8,
  parameter int BURST_W = 4,
  parameter int GAP_HP  = 4,
  parameter int CH_W    = NUM_CH > 1 ? $clog2(NUM_CH) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_we,
  input  logic [CH_W-1:0]    cfg_ch,
  input  logic [1:0]         cfg_mode,
  input  logic [RATE_W-1:0]  cfg_rate,
  input  logic [BURST_W-1:0] cfg_burst,
  output logic [NUM_CH-1:0]  led,
  output logic               tick
);
  localparam int TICK_DIV = CLK_HZ / TICK_HZ;
  localparam int PS_W = $clog2(TICK_DIV);
  logic [PS_W-1:0] ps;
  assign tick = ps == PS_W'(TICK_DIV - 1);
  always_ff @(posedge clk) begin
    if (rst) ps <= '0;
    else ps <= tick ? '0 : ps + 1'b1;
  end
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    led_channel #(.RATE_W(RATE_W), .BURST_W(BURST_W), .GAP_HP(GAP_HP)) u_ch (
      .clk   (clk),
      .rst   (rst),
      .tick  (tick),
      .load  (cfg_we && cfg_ch == CH_W'(i)),
      .mode  (cfg_mode),
      .rate  (cfg_rate),
      .burst (cfg_burst),
      .led   (led[i])
    );
  end
endmodule

// File: tb/tb_led_pattern_gen.sv
// tb_led_pattern_gen: directed checks of prescaler, channel modes and config write handling
module tb_led_pattern_gen;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cfg_we = 1'b0;
  logic [2:0] cfg_ch = '0;
  logic [1:0] cfg_mode = '0;
  logic [7:0] cfg_rate = '0;
  logic [3:0] cfg_burst = '0;
  logic [3:0] led;
  logic       tick;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  led_pattern_gen #(
    .CLK_HZ(1000), .TICK_HZ(100), .NUM_CH(4), .RATE_W(8), .BURST_W(4), .GAP_HP(4), .CH_W(3)
  ) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_mode(cfg_mode),
    .cfg_rate(cfg_rate), .cfg_burst(cfg_burst), .led(led), .tick(tick)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic do_reset();
    rst = 1'b1;
    step(3);
    rst = 1'b0;
  endtask
  task automatic wait_tick();
    int i = 0;
    while (!tick && i < 20) begin
      step();
      i++;
    end
    chk("tick_wait", 32'(tick), 1);
  endtask
  // align=1 lands the write on a tick so the first phase is full length
  task automatic cfg(input int ch, input int mode, input int rate, input int burst, input bit align);
    if (align) wait_tick();
    cfg_we = 1'b1;
    cfg_ch = 3'(ch);
    cfg_mode = 2'(mode);
    cfg_rate = 8'(rate);
    cfg_burst = 4'(burst);
    step();
    cfg_we = 1'b0;
  endtask
  task automatic run_len(input int b, output int len);
    logic v;
    v = led[b];
    len = 0;
    do begin
      step();
      len++;
    end while (led[b] == v && len < 1000);
  endtask
  task automatic count_high(input int b, input int n, output int hi);
    hi = 0;
    repeat (n) begin
      step();
      hi += int'(led[b]);
    end
  endtask
  task automatic count_nz(input int n, output int nz);
    nz = 0;
    repeat (n) begin
      step();
      nz += int'(led != 4'b0000);
    end
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    int tk, l, h, bad;
    int exp_b[8] = '{20, 20, 20, 20, 20, 100, 20, 20};
    logic e3;
    step(3);
    rst = 1'b0;
    chk("rst_led", 32'(led), 0);
    chk("rst_tick", 32'(tick), 0);
    tk = 0;
    for (int n = 1; n <= 29; n++) begin
      step();
      tk += int'(tick);
      if (n % 10 == 9) chk("tick_pos", 32'(tick), 1);
    end
    chk("tick_cnt", 32'(tk), 3);
    cfg(0, 2, 3, 0, 1);
    chk("blink_lat", 32'(led[0]), 0);
    step();
    chk("blink_rise", 32'(led), 32'b0001);
    run_len(0, l); chk("blink_hi", 32'(l), 30);
    run_len(0, l); chk("blink_lo", 32'(l), 30);
    run_len(0, l); chk("blink_hi2", 32'(l), 30);
    chk("blink_others", 32'(led[3:1]), 0);
    run_len(0, l); chk("blink_lo2", 32'(l), 30);
    step(5);
    chk("mid_high", 32'(led[0]), 1);
    rst = 1'b1;
    step();
    chk("rst_mid", 32'(led), 0);
    step(2);
    rst = 1'b0;
    count_high(0, 40, h);
    chk("rst_stay", 32'(h), 0);
    cfg(1, 3, 2, 3, 1);
    step();
    chk("burst_rise", 32'(led[1]), 1);
    for (int i = 0; i < 8; i++) begin
      run_len(1, l);
      chk($sformatf("burst_run%0d", i), 32'(l), 32'(exp_b[i]));
    end
    do_reset();
    cfg(0, 2, 0, 0, 1);
    step();
    chk("rate0_rise", 32'(led[0]), 1);
    run_len(0, l); chk("rate0_hi", 32'(l), 10);
    run_len(0, l); chk("rate0_lo", 32'(l), 10);
    run_len(0, l); chk("rate0_hi2", 32'(l), 10);
    cfg(1, 3, 5, 0, 0);
    count_high(1, 100, h);
    chk("burst0_low", 32'(h), 0);
    cfg(2, 1, 0, 0, 0);
    count_high(2, 100, h);
    chk("on_high", 32'(h), 100);
    cfg(0, 2, 3, 0, 1);
    step(6);
    chk("recfg_on", 32'(led[0]), 1);
    cfg(0, 0, 3, 0, 0);
    chk("recfg_hold", 32'(led[0]), 1);
    step();
    chk("recfg_off", 32'(led[0]), 0);
    count_high(0, 50, h);
    chk("recfg_stay", 32'(h), 0);
    do_reset();
    cfg(5, 1, 1, 0, 0);
    cfg(4, 2, 1, 0, 0);
    count_nz(30, h);
    chk("bad_ch", 32'(h), 0);
    rst = 1'b1;
    cfg_we = 1'b1;
    cfg_ch = 3'd0;
    cfg_mode = 2'd1;
    step();
    rst = 1'b0;
    cfg_we = 1'b0;
    count_nz(30, h);
    chk("rst_we", 32'(h), 0);
    do_reset();
    cfg(2, 1, 0, 0, 0);
    cfg(3, 2, 1, 0, 1);
    bad = 0;
    for (int k = 1; k <= 200; k++) begin
      cfg_we = (k % 7 == 0) || tick;
      cfg_ch = 3'd0;
      cfg_mode = 2'(k % 4);
      cfg_rate = 8'(k % 5);
      cfg_burst = 4'(k % 3);
      step();
      cfg_we = 1'b0;
      e3 = ((k - 1) / 10) % 2 == 0;
      bad += int'(led[3] != e3) + int'(led[2] != 1'b1);
    end
    chk("indep", 32'(bad), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/led_pattern_gen.md
Name: led_pattern_gen

Overview:
- Multi-channel LED pattern generator. It is the parametrised successor of the free-running single-LED blink counter.
- A shared prescaler produces a slow tick from the 50 MHz board clock.
- Each of NUM_CH channels runs an independent mode (off, on, blink, burst) with a runtime-programmable half-period and burst count.
- Sits at board top level; any control logic or test harness drives the config port.

Parameters:
- CLK_HZ, 50000000, input clock frequency.
- TICK_HZ, 1000, prescaler tick rate (1 ms). TICK_DIV = CLK_HZ/TICK_HZ, must be >= 2.
- NUM_CH, 4, number of LED channels, 1..16.
- RATE_W, 8, width of half-period field, in ticks.
- BURST_W, 4, width of burst-count field.
- GAP_HP, 4, half-periods of forced off-time after each burst, >= 1.

Ports:
- clk  in  1  system clock, CLK_HZ.
- rst  in  1  synchronous, active-high reset.
- cfg_we  in  1  config write strobe, one cycle.
- cfg_ch  in  max(1,$clog2(NUM_CH))  target channel.
- cfg_mode  in  2  0=OFF, 1=ON, 2=BLINK, 3=BURST.
- cfg_rate  in  RATE_W  half-period in ticks; 0 is treated as 1.
- cfg_burst  in  BURST_W  pulses per burst.
- led  out  NUM_CH  LED drive, one bit per channel, registered.
- tick  out  1  prescaler tick, one cycle high every TICK_DIV cycles.

Behaviour:
- Reset (rst=1 at posedge):
  - prescaler = 0; tick = 0; led = 0.
  - Every channel: mode=OFF, rate=1, burst=0, state=IDLE, phase counter and pulse counter cleared.
  - rst has priority over cfg_we in the same cycle.
- Prescaler:
  - Counts 0..TICK_DIV-1 and wraps.
  - tick = 1 exactly in the cycles where count == TICK_DIV-1.
  - First tick after rst release occurs in the TICK_DIV-th cycle.
  - Config writes never disturb the prescaler.
- Config write (cfg_we=1, cfg_ch < NUM_CH):
  - Channel latches mode, rate_eff = max(cfg_rate,1), and burst.
  - Clears phase and pulse counters.
  - Enters its start state at the next posedge.
  - cfg_ch >= NUM_CH: write ignored, no channel changes.
  - Non-addressed channels are unaffected.
  - A write coinciding with tick: the write wins and that tick is not counted.
- Channel states: IDLE, PH_ON, PH_OFF, GAP.
  - OFF: state IDLE, led=0.
  - ON: state IDLE, led=1.
  - BLINK: start PH_ON.
    - PH_ON -> PH_OFF -> PH_ON, advancing on the tick where the phase counter == rate_eff-1 (counter then resets to 0).
    - Steady-state period is 2*rate_eff ticks.
  - BURST with burst=0: state IDLE, led=0.
  - BURST with burst>0: start PH_ON.
    - PH_ON ends -> pulse_cnt++, go to PH_OFF.
    - PH_OFF ends -> GAP if pulse_cnt == burst, else PH_ON.
    - GAP lasts GAP_HP*rate_eff ticks, then pulse_cnt=0 and go to PH_ON.
    - Period is (2*burst + GAP_HP)*rate_eff ticks.
- led timing:
  - led=1 exactly in PH_ON, 0 in PH_OFF/GAP.
  - led is registered; it reflects the new state in the cycle after the state changes, one cycle of latency.
  - After a write to BLINK/BURST, led rises two cycles after the cfg_we cycle.
- First phase after a write: ends on the rate_eff-th tick following the write, so it may be up to TICK_DIV-1 cycles short. This is accepted.
- Mode change mid-phase: the old phase is abandoned immediately, with no completion of the pending pulse.
- Widths:
  - Phase counter sized for the GAP length: RATE_W + $clog2(GAP_HP+1) bits.
  - pulse_cnt is BURST_W bits and never wraps, since the comparison happens before the increment overflows.

Decomposition:
- Package led_pattern_pkg holds:
  - mode_t enum (OFF/ON/BLINK/BURST, 2 bits).
  - chan_state_t enum (IDLE/PH_ON/PH_OFF/GAP).
  - Mode encoding constants.
- Sub-module led_channel: one instance per channel via generate.
  - Holds that channel's config registers, FSM, and counters.
  - Inputs: clk, rst, tick, load, mode/rate/burst.
  - Output: led bit.
- Top level holds the prescaler, the address decode into per-channel load strobes, and the generate loop.

Test Plan (CLK_HZ=1000, TICK_HZ=100 -> TICK_DIV=10; NUM_CH=4, GAP_HP=4):
- Reset: hold rst 3 cycles, release -> led=4'b0000, and tick high in cycle 10, 20, 30 after release; rst asserted mid-blink -> led=0 on the next cycle and stays 0.
- BLINK ch0, rate=3 -> led[0] rises 2 cycles after write; steady state 30 cycles high / 30 cycles low; other bits stay 0.
- BURST ch1, rate=2, burst=3 -> three 20-cycle high pulses separated by 20-cycle lows, then low for 100 cycles (last OFF + GAP); pattern repeats every 200 cycles.
- Edge values:
  - rate=0 on BLINK behaves identically to rate=1 (10-cycle half-period).
  - BURST with burst=0 -> led low permanently.
  - ON mode -> led high permanently.
- Write handling:
  - Reconfigure ch0 mid PH_ON to OFF -> led[0]=0 two cycles later.
  - Write with cfg_ch=5 (with $clog2 width 3, NUM_CH=4 setup using a wider cfg_ch variant) -> no led change.
  - rst and cfg_we in the same cycle -> reset state, write discarded.
- Independence: ch2 ON, ch3 BLINK rate=1 running; rewrite ch0 repeatedly, including on tick cycles -> ch2 and ch3 waveforms are cycle-identical to a run without the ch0 writes.
